// File: rtl/spmv_vec_prefetch.sv
// spmv_vec_prefetch: fetches a dense vector as 64 B lines into a local buffer and serves 32-bit element reads
module spmv_vec_prefetch #(
   parameter int NUM_LINES       = 16,
   parameter int MAX_OUTSTANDING = 8,
   parameter int IDX_W           = $clog2(NUM_LINES*16)+1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             busy,
   input  logic [39:0]      base_addr,
   input  logic [19:0]      vec_len,
   output logic             done,
   output logic             err,
   input  logic             mem_req_rdy,
   output logic             mem_req_val,
   output logic [5:0]       mem_req_transid,
   output logic [39:0]      mem_req_addr,
   input  logic             mem_resp_val,
   input  logic [5:0]       mem_resp_transid,
   input  logic [511:0]     mem_resp_data,
   input  logic             rd_val,
   input  logic [IDX_W-1:0] rd_idx,
   output logic             rd_data_val,
   output logic             rd_hit,
   output logic [31:0]      rd_data
);
   localparam int LW = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
   localparam int RW = IDX_W + 1;
   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
   state_t               state;
   logic [33:0]          line_base;
   logic [3:0]           off;
   logic [26:0]          n_lines, n_calc;
   logic [6:0]           issue_ptr, out_cnt;
   logic [NUM_LINES-1:0] valid, out_bm, iss_oh, resp_oh, mask;
   logic [511:0]         lines [NUM_LINES];
   logic                 hs, resp_ok, over, all_valid, rd_ok;
   logic [LW-1:0]        rid, rli;
   logic [RW-1:0]        ra;

   assign n_calc          = (27'(base_addr[5:0]) + {5'd0, vec_len, 2'd0} + 27'd63) >> 6;
   assign over            = n_calc > 27'(NUM_LINES);
   assign mem_req_val     = state == ISSUE && 27'(issue_ptr) < n_lines && out_cnt < 7'(MAX_OUTSTANDING);
   assign mem_req_addr    = {line_base + 34'(issue_ptr), 6'd0};
   assign mem_req_transid = issue_ptr[5:0];
   assign hs              = mem_req_val & mem_req_rdy;
   assign rid             = mem_resp_transid[LW-1:0];
   assign resp_ok         = mem_resp_val && 27'(mem_resp_transid) < n_lines && out_bm[rid];
   assign all_valid       = &(valid | resp_oh | ~mask);
   // element address in words: ra[3:0] selects the word, upper bits select the line
   assign ra              = RW'(off) + RW'(rd_idx);
   assign rli             = ra[LW+3:4];
   assign rd_ok           = rd_val && 27'(ra[RW-1:4]) < n_lines && valid[rli];

   // per-line decode of the active range, the issuing line and the accepted response
   always_comb begin
      mask    = '0;
      iss_oh  = '0;
      resp_oh = '0;
      for (int i = 0; i < NUM_LINES; i++) begin
         mask[i]    = 27'(i) < n_lines;
         iss_oh[i]  = hs && issue_ptr == 7'(i);
         resp_oh[i] = resp_ok && rid == LW'(i);
      end
   end

   // control FSM plus request/outstanding/valid bookkeeping
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         line_base <= '0;
         off       <= '0;
         n_lines   <= '0;
         issue_ptr <= '0;
         out_cnt   <= '0;
         valid     <= '0;
         out_bm    <= '0;
      end else begin
         done      <= 1'b0;
         issue_ptr <= issue_ptr + 7'(hs);
         out_cnt   <= out_cnt + 7'(hs) - 7'(resp_ok);
         out_bm    <= (out_bm | iss_oh) & ~resp_oh;
         valid     <= valid | resp_oh;
         case (state)
            IDLE: if (start) begin
               line_base <= base_addr[39:6];
               off       <= base_addr[5:2];
               n_lines   <= n_calc;
               issue_ptr <= '0;
               out_cnt   <= '0;
               out_bm    <= '0;
               valid     <= '0;
               err       <= over;
               busy      <= 1'b1;
               state     <= (vec_len == '0 || over) ? DONE : ISSUE;
               done      <= vec_len == '0 || over;
            end
            ISSUE: if (hs && 27'(issue_ptr) + 27'd1 == n_lines) state <= DRAIN;
            DRAIN: if (all_valid) begin
               state <= DONE;
               done  <= 1'b1;
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // line buffer write on accepted response
   always_ff @(posedge clk) begin
      if (resp_ok) lines[rid] <= mem_resp_data;
   end

   // one-cycle element read; misses return zero
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data_val <= 1'b0;
         rd_hit      <= 1'b0;
         rd_data     <= '0;
      end else begin
         rd_data_val <= rd_val;
         rd_hit      <= rd_ok;
         rd_data     <= rd_ok ? lines[rli][{ra[3:0], 5'd0} +: 32] : '0;
      end
   end
endmodule

// File: doc/spmv_vec_prefetch.md
Name: spmv_vec_prefetch

Overview:
- Dense-vector prefetch stage directly downstream of the SpMV command interface (tight_acc_iface).
- After the command interface has latched the vector pointer and length, it starts this block, which fetches the vector as 64-byte lines over the DCP memory request/response channel.
- Returned lines go into a local line buffer; the block signals completion to the command interface FSM.
- The compute datapath reads 32-bit vector elements out of the buffer by element index.

Parameters:
- NUM_LINES, 16: line-buffer depth in 64 B lines; legal 1..64; capacity = NUM_LINES*16 elements.
- MAX_OUTSTANDING, 8: maximum in-flight memory requests; legal 1..NUM_LINES.
- IDX_W, $clog2(NUM_LINES*16)+1: width of the element read index.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin prefetch; accepted only when busy=0
- busy  out  1  high from accepted start until done cycle inclusive
- base_addr  in  40  vector physical byte address; bits [1:0] assumed 0
- vec_len  in  20  vector length in 32-bit elements
- done  out  1  one-cycle pulse when all lines are resident or on error
- err  out  1  sticky; set on an over-capacity start; cleared by the next accepted start
- mem_req_rdy  in  1  network accepts request
- mem_req_val  out  1  request valid
- mem_req_transid  out  6  line index of the request
- mem_req_addr  out  40  line-aligned request address
- mem_resp_val  in  1  response valid; always accepted
- mem_resp_transid  in  6  line index of the response
- mem_resp_data  in  512  64 B line; element k in bits [32k+31:32k]
- rd_val  in  1  element read request
- rd_idx  in  IDX_W  element index relative to base_addr
- rd_data_val  out  1  rd_val delayed one cycle
- rd_hit  out  1  the addressed line was resident at request time
- rd_data  out  32  element data; 0 when rd_hit=0

Behaviour:
- Reset: every output 0; FSM=IDLE; valid bitmap, counters and err cleared. Reset mid-operation abandons everything in flight. Responses arriving after reset target non-outstanding transids and are dropped.
- Start in IDLE latches the following:
  - line_base = base_addr & ~63
  - off = base_addr[5:0]
  - n_lines = ceil((off + 4*vec_len)/64), computed at 27 bits with no overflow
- Start handling:
  - vec_len=0: no requests; done pulses the cycle after start; FSM returns to IDLE.
  - n_lines > NUM_LINES: err set, no requests, done pulses the next cycle.
  - start while busy=1: ignored.
- FSM: IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
- ISSUE:
  - mem_req_val=1 while issue_ptr<n_lines and outstanding<MAX_OUTSTANDING.
  - addr = line_base + 64*issue_ptr; transid = issue_ptr[5:0].
  - Handshake (val&rdy): issue_ptr++ and outstanding++.
  - First request is presented the cycle after start.
  - Move to DRAIN when issue_ptr==n_lines after a handshake.
  - mem_req_val/addr/transid stay stable while val=1 and rdy=0.
- Response acceptance:
  - A response is accepted in any state when its transid<n_lines and the line is marked outstanding.
  - It writes line[transid], sets valid[transid], clears outstanding[transid], and decrements outstanding.
  - A same-cycle handshake plus response leaves outstanding unchanged.
  - Other responses are dropped without state change.
  - Out-of-order return is legal.
- DRAIN -> DONE when all n_lines valid bits are set, including a final response arriving that cycle. DONE asserts done for one cycle, then IDLE; busy drops in the IDLE cycle.
- Buffer contents and valid bits persist after DONE; they are cleared only on the next accepted start or reset.
- Reads, 1-cycle latency, legal in any state:
  - a = off + 4*rd_idx; line = a>>6; word = a[5:2].
  - rd_hit = valid[line] && line<n_lines, sampled in the rd_val cycle.
  - A read of a line whose response arrives in the same cycle returns miss.

Test Plan:
- base=0x1000, len=32, rdy=1, in-order responses: 2 requests (0x1000 tid0, 0x1040 tid1); done one cycle after the 2nd response; rd_idx=17 returns the word at bits [63:32] of line1.
- base=0x2038, len=4: n_lines=2, requests 0x2000 and 0x2040; rd_idx=2 returns line1 word0.
- len=256, MAX_OUTSTANDING=8, no responses: exactly 8 handshakes then mem_req_val=0; one response re-enables one request.
- mem_req_rdy held low 5 cycles: val/addr/transid stable; responses returned in order 3,1,0,2; done only after tid2.
- len=0 -> done next cycle, err=0, no requests; len=300 (NUM_LINES=16) -> err=1, done next cycle, no requests.
- Assert rst while 4 requests are in flight, restart, then inject stale tid5: dropped; rd_idx of an unfetched line gives rd_hit=0, rd_data=0.
